// File: rtl/onehot_step_sequencer.sv
// ---------------------------------------------------------------------------
// onehot_step_sequencer
//
// One-hot step sequencer. The state is held as NS bits, one per state.
// st_o[0] is IDLE and st_o[1]..st_o[NS-1] are the active steps. Each active
// step dwells for a programmable number of cycles (dwell_cfg[k*CW +: CW] + 1).
// Control inputs give hold, abort and loop/one-shot behaviour. Completion,
// wrap and abort are reported as one-cycle pulses.
//
// Parameters
//   NS  number of states including IDLE (>= 3)
//   CW  dwell-counter width
//
// Ports
//   clk        in   clock, all flops on posedge
//   rst_b      in   asynchronous active-low reset
//   start      in   launch the sequence (honoured only in IDLE)
//   hold       in   freeze the current step and its counter
//   abort      in   return to IDLE on the next edge (active steps only)
//   loop       in   1: step NS-1 is followed by step 1; 0: by IDLE
//   dwell_cfg  in   per-step dwell, step k in bits [k*CW +: CW]; slice 0 unused
//   st_o       out  one-hot state register
//   busy       out  ~st_o[0] (combinational)
//   done       out  one-cycle pulse on one-shot completion
//   wrap       out  one-cycle pulse when looping from step NS-1 to step 1
//   aborted    out  one-cycle pulse when an abort is taken
//   err        out  sticky illegal-state flag
//
// Build option
//   ONEHOT_CHECK_EN  when defined, a state register that is not exactly
//                    one-hot forces IDLE, clears the counter and sets err
//                    until reset. When undefined, err is tied to 0 and no
//                    checking logic is built.
// ---------------------------------------------------------------------------
module onehot_step_sequencer #(
  parameter int NS = 6,
  parameter int CW = 4
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               start,
  input  logic               hold,
  input  logic               abort,
  input  logic               loop,
  input  logic [NS*CW-1:0]   dwell_cfg,
  output logic [NS-1:0]      st_o,
  output logic               busy,
  output logic               done,
  output logic               wrap,
  output logic               aborted,
  output logic               err
);

  logic [NS-1:0]         r_st;
  logic [CW-1:0]         r_cnt;
  logic                  r_done;
  logic                  r_wrap;
  logic                  r_aborted;

  logic [NS-1:0]         w_st_next;
  logic [CW-1:0]         w_cnt_next;
  logic                  w_active;
  logic                  w_cnt_zero;
  logic                  w_run;
  logic [NS-1:0]         w_adv;     // leaving step k this edge (count expired)
  logic [NS-1:0]         w_stay;    // remaining in step k this edge
  logic [NS-1:0][CW-1:0] w_entry_term;
  logic [CW-1:0]         w_entry_dwell;
  logic                  w_done_next;
  logic                  w_wrap_next;
  logic                  w_aborted_next;

  // The IDLE slice of dwell_cfg has no meaning; fold it into a sink.
  logic                  w_unused_slice0;
  assign w_unused_slice0 = ^dwell_cfg[CW-1:0];

  assign w_active   = |r_st[NS-1:1];
  assign w_cnt_zero = (r_cnt == '0);
  assign w_run      = ~abort & ~hold;

  // Per-step exit/stay terms. Bit 0 (IDLE) is handled separately.
  assign w_adv[0]  = 1'b0;
  assign w_stay[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NS; gi++) begin : g_step_terms
      assign w_adv[gi]  = r_st[gi] & w_run & w_cnt_zero;
      assign w_stay[gi] = r_st[gi] & ~abort & (hold | ~w_cnt_zero);
    end
  endgenerate

  // Next-state equations, one per state bit.
  // IDLE: stay without start, one-shot completion, or abort of any step.
  assign w_st_next[0] = (r_st[0] & ~start)
                      | (w_adv[NS-1] & ~loop)
                      | (w_active & abort);
  // Step 1: launched from IDLE, held/counting, or wrapped from the last step.
  assign w_st_next[1] = (r_st[0] & start)
                      | w_stay[1]
                      | (w_adv[NS-1] & loop);
  generate
    for (genvar gi = 2; gi < NS; gi++) begin : g_st_next
      assign w_st_next[gi] = w_stay[gi] | w_adv[gi-1];
    end
  endgenerate

  // Dwell value loaded when a step is exited on an expired count. Only one
  // term can be non-zero because the state is one-hot.
  assign w_entry_term[0] = '0;
  generate
    for (genvar gi = 1; gi < NS - 1; gi++) begin : g_entry_mid
      assign w_entry_term[gi] = {CW{w_adv[gi]}} & dwell_cfg[(gi+1)*CW +: CW];
    end
  endgenerate
  // Last step: wrap reloads step 1's dwell, one-shot completion clears.
  assign w_entry_term[NS-1] = {CW{w_adv[NS-1] & loop}} & dwell_cfg[CW +: CW];

  always_comb begin
    w_entry_dwell = '0;
    for (int k = 0; k < NS; k++) begin
      w_entry_dwell = w_entry_dwell | w_entry_term[k];
    end
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (r_st[0]) begin
      if (start) begin
        w_cnt_next = dwell_cfg[CW +: CW];
      end
    end else if (abort) begin
      w_cnt_next = '0;
    end else if (hold) begin
      w_cnt_next = r_cnt;
    end else if (!w_cnt_zero) begin
      w_cnt_next = r_cnt - CW'(1);
    end else begin
      w_cnt_next = w_entry_dwell;
    end
  end

  assign w_done_next    = w_adv[NS-1] & ~loop;
  assign w_wrap_next    = w_adv[NS-1] & loop;
  assign w_aborted_next = w_active & abort;

`ifdef ONEHOT_CHECK_EN
  logic r_err;
  logic w_bad;
  // Zero bits set, or more than one bit set (clearing the lowest set bit
  // leaves something behind).
  assign w_bad = (r_st == '0) | ((r_st & (r_st - NS'(1))) != '0);
  assign err   = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_st      <= NS'(1);
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_wrap    <= 1'b0;
      r_aborted <= 1'b0;
`ifdef ONEHOT_CHECK_EN
      r_err     <= 1'b0;
`endif
    end else begin
`ifdef ONEHOT_CHECK_EN
      if (w_bad) begin
        // Recovery cycle: back to IDLE, no pulses, flag latched.
        r_st      <= NS'(1);
        r_cnt     <= '0;
        r_done    <= 1'b0;
        r_wrap    <= 1'b0;
        r_aborted <= 1'b0;
        r_err     <= 1'b1;
      end else
`endif
      begin
        r_st      <= w_st_next;
        r_cnt     <= w_cnt_next;
        r_done    <= w_done_next;
        r_wrap    <= w_wrap_next;
        r_aborted <= w_aborted_next;
      end
    end
  end

  assign st_o    = r_st;
  assign busy    = ~r_st[0];
  assign done    = r_done;
  assign wrap    = r_wrap;
  assign aborted = r_aborted;

endmodule

// File: tb/tb_onehot_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_onehot_step_sequencer
//
// Directed bench for onehot_step_sequencer (NS=6, CW=4). Inputs are driven
// 1 time unit after a rising edge and outputs are sampled at that same point,
// so every sample reflects the state registered at the preceding edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_onehot_step_sequencer;

  localparam int NS = 6;
  localparam int CW = 4;

  logic               clk;
  logic               rst_b;
  logic               start;
  logic               hold;
  logic               abort;
  logic               loop;
  logic [NS*CW-1:0]   dwell_cfg;
  logic [NS-1:0]      st_o;
  logic               busy;
  logic               done;
  logic               wrap;
  logic               aborted;
  logic               err;

  int n_checks;
  int n_pass;

  onehot_step_sequencer #(.NS(NS), .CW(CW)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .hold      (hold),
    .abort     (abort),
    .loop      (loop),
    .dwell_cfg (dwell_cfg),
    .st_o      (st_o),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap),
    .aborted   (aborted),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dwell(input int k, input logic [CW-1:0] v);
    dwell_cfg[k*CW +: CW] = v;
  endtask

  // Advance until st_o equals target or the cycle budget runs out.
  task automatic wait_state(input logic [NS-1:0] target, input int max_cyc,
                            output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      if (st_o == target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (st_o == target) ok = 1'b1;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    logic [NS-1:0] exp_st;
    bit ok;
    exp_st = NS'(1);
    dwell_cfg = '0;
    set_dwell(3, 4'd5);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_state(6'b001000, 10, ok);
    // Asynchronous reset in the middle of a cycle, no clock edge involved.
    #2 rst_b = 1'b0;
    #1;
    n_checks++;
    if (st_o !== exp_st || busy !== 1'b0) begin
      $display("FAIL reset_state: st_o=%b busy=%b, required st_o=%b busy=0", st_o, busy, exp_st);
    end else n_pass++;
    n_checks++;
    if (done !== 1'b0 || wrap !== 1'b0 || aborted !== 1'b0 || err !== 1'b0) begin
      $display("FAIL reset_pulses: done=%b wrap=%b aborted=%b err=%b, required all 0", done, wrap, aborted, err);
    end else n_pass++;
    @(negedge clk);
    rst_b = 1'b1;
    tick();
    n_checks++;
    if (st_o !== exp_st || done !== 1'b0 || aborted !== 1'b0) begin
      $display("FAIL reset_release: st_o=%b done=%b aborted=%b, required st_o=%b no pulses", st_o, done, aborted, exp_st);
    end else n_pass++;
    $display("test_reset: st_o=%b busy=%b err=%b", st_o, busy, err);
  endtask

  // ---------------------------------------------------------------------
  task automatic test_oneshot();
    logic [NS-1:0] exp_st;
    int bad;
    dwell_cfg = '0;
    loop  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    bad = 0;
    for (int k = 1; k < NS; k++) begin
      exp_st = NS'(1) << k;
      if (st_o !== exp_st || busy !== 1'b1 || done !== 1'b0) begin
        $display("FAIL oneshot_step%0d: st_o=%b busy=%b done=%b, required st_o=%b busy=1 done=0", k, st_o, busy, done, exp_st);
        bad++;
      end
      tick();
    end
    n_checks++;
    if (bad == 0) n_pass++;
    exp_st = NS'(1);
    n_checks++;
    if (st_o !== exp_st || done !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL oneshot_done: st_o=%b done=%b busy=%b, required st_o=%b done=1 busy=0", st_o, done, busy, exp_st);
    end else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b0 || st_o !== exp_st) begin
      $display("FAIL oneshot_done_width: done=%b st_o=%b, required done=0 st_o=%b", done, st_o, exp_st);
    end else n_pass++;
    $display("test_oneshot: walked steps 1..%0d, done observed", NS-1);
  endtask

  // ---------------------------------------------------------------------
  // Count cycles spent in step 2. dwell_cfg for step 2 is cleared right
  // after entry, which must not shorten the running count.
  task automatic measure_step2(input bit use_hold, output int n, output bit ok);
    int holds;
    n = 0;
    holds = 0;
    dwell_cfg = '0;
    set_dwell(2, 4'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (st_o == 6'b000001) begin
        ok = 1'b1;
        break;
      end
      if (st_o == 6'b000100) begin
        n++;
        set_dwell(2, 4'd0);
      end
      hold = use_hold && (n >= 1) && (holds < 2);
      if (hold) holds++;
      tick();
    end
    hold = 1'b0;
  endtask

  task automatic test_dwell_hold();
    int n;
    bit ok;
    measure_step2(1'b0, n, ok);
    n_checks++;
    if (!ok || n != 4) begin
      $display("FAIL dwell_step2: cycles=%0d returned=%b, required cycles=4 returned=1", n, ok);
    end else n_pass++;
    $display("test_dwell: step2 cycles=%0d", n);
    measure_step2(1'b1, n, ok);
    n_checks++;
    if (!ok || n != 6) begin
      $display("FAIL hold_step2: cycles=%0d returned=%b, required cycles=6 returned=1", n, ok);
    end else n_pass++;
    $display("test_hold: step2 cycles=%0d", n);
  endtask

  // ---------------------------------------------------------------------
  task automatic test_abort();
    bit ok;
    dwell_cfg = '0;
    set_dwell(3, 4'd2);
    loop  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_state(6'b001000, 10, ok);
    n_checks++;
    if (!ok) begin
      $display("FAIL abort_reach_step3: st_o=%b, required 001000", st_o);
    end else n_pass++;
    abort = 1'b1;
    hold  = 1'b1;
    tick();
    abort = 1'b0;
    hold  = 1'b0;
    n_checks++;
    if (st_o !== 6'b000001 || aborted !== 1'b1 || done !== 1'b0 || wrap !== 1'b0) begin
      $display("FAIL abort_taken: st_o=%b aborted=%b done=%b wrap=%b, required 000001 1 0 0", st_o, aborted, done, wrap);
    end else n_pass++;
    // Relaunch from the IDLE cycle that carries the aborted pulse.
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (st_o !== 6'b000010 || aborted !== 1'b0) begin
      $display("FAIL abort_relaunch: st_o=%b aborted=%b, required 000010 0", st_o, aborted);
    end else n_pass++;
    // start while busy is ignored: step 2 moves on to step 3.
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (st_o !== 6'b001000) begin
      $display("FAIL start_while_busy: st_o=%b, required 001000", st_o);
    end else n_pass++;
    wait_state(6'b000001, 20, ok);
    // start+abort in IDLE: start wins.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    n_checks++;
    if (!ok || st_o !== 6'b000010 || aborted !== 1'b0) begin
      $display("FAIL start_abort_idle: st_o=%b aborted=%b idle_seen=%b, required 000010 0 1", st_o, aborted, ok);
    end else n_pass++;
    wait_state(6'b000001, 20, ok);
    // hold in IDLE has no effect on a launch.
    hold  = 1'b1;
    start = 1'b1;
    tick();
    hold  = 1'b0;
    start = 1'b0;
    n_checks++;
    if (!ok || st_o !== 6'b000010) begin
      $display("FAIL hold_idle: st_o=%b, required 000010", st_o);
    end else n_pass++;
    wait_state(6'b000001, 20, ok);
    $display("test_abort: abort, relaunch, start+abort, hold-in-idle exercised");
  endtask

  // ---------------------------------------------------------------------
  task automatic test_loop();
    logic [NS-1:0] exp_st;
    int bad;
    bit ok;
    dwell_cfg = '0;
    loop  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < NS; k++) tick();
    n_checks++;
    if (st_o !== 6'b000010 || wrap !== 1'b1 || done !== 1'b0) begin
      $display("FAIL loop_wrap: st_o=%b wrap=%b done=%b, required 000010 1 0", st_o, wrap, done);
    end else n_pass++;
    loop = 1'b0;
    tick();
    n_checks++;
    if (st_o !== 6'b000100 || wrap !== 1'b0) begin
      $display("FAIL loop_wrap_width: st_o=%b wrap=%b, required 000100 0", st_o, wrap);
    end else n_pass++;
    bad = 0;
    for (int k = 3; k < NS; k++) begin
      tick();
      exp_st = NS'(1) << k;
      if (st_o !== exp_st || wrap !== 1'b0 || done !== 1'b0) begin
        $display("FAIL loop_second_pass%0d: st_o=%b wrap=%b done=%b, required %b 0 0", k, st_o, wrap, done, exp_st);
        bad++;
      end
    end
    n_checks++;
    if (bad == 0) n_pass++;
    tick();
    n_checks++;
    if (st_o !== 6'b000001 || done !== 1'b1 || wrap !== 1'b0) begin
      $display("FAIL loop_drop_done: st_o=%b done=%b wrap=%b, required 000001 1 0", st_o, done, wrap);
    end else n_pass++;
    wait_state(6'b000001, 4, ok);
    $display("test_loop: wrap then one-shot completion");
  endtask

  // ---------------------------------------------------------------------
  task automatic test_onehot_check();
`ifdef ONEHOT_CHECK_EN
    bit ok;
    dwell_cfg = '0;
    set_dwell(2, 4'd4);
    @(negedge clk);
    force dut.r_st = 6'b001100;
    #1;
    release dut.r_st;
    tick();
    n_checks++;
    if (st_o !== 6'b000001 || err !== 1'b1 || done !== 1'b0 || wrap !== 1'b0 || aborted !== 1'b0) begin
      $display("FAIL onehot_recover: st_o=%b err=%b pulses=%b%b%b, required 000001 1 000", st_o, err, done, wrap, aborted);
    end else n_pass++;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_state(6'b000001, 30, ok);
    n_checks++;
    if (!ok || err !== 1'b1) begin
      $display("FAIL onehot_sticky: err=%b idle_seen=%b, required 1 1", err, ok);
    end else n_pass++;
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    n_checks++;
    if (err !== 1'b0) begin
      $display("FAIL onehot_clear: err=%b, required 0", err);
    end else n_pass++;
    @(negedge clk);
    rst_b = 1'b1;
    tick();
    $display("test_onehot_check: err raised, held, cleared by reset");
`else
    bit ok;
    dwell_cfg = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_state(6'b000001, 20, ok);
    n_checks++;
    if (!ok || err !== 1'b0) begin
      $display("FAIL err_tied: err=%b idle_seen=%b, required 0 1", err, ok);
    end else n_pass++;
    $display("test_onehot_check: err tied low in this build");
`endif
  endtask

  // ---------------------------------------------------------------------
  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_b     = 1'b0;
    start     = 1'b0;
    hold      = 1'b0;
    abort     = 1'b0;
    loop      = 1'b0;
    dwell_cfg = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
    tick();

    test_reset();
    test_oneshot();
    test_dwell_hold();
    test_abort();
    test_loop();
    test_onehot_check();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
